// File: rtl/pong_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pong_game_ctrl
//  Purpose  : Pong match sequencer. Synchronises the start button, runs the
//             IDLE -> SERVE -> PLAY -> POINT -> OVER flow, keeps both scores,
//             picks the serve direction and declares the winner.
//  Revision : 1.0  initial release
// ============================================================================
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       frame_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic [2:0] state,
  output logic       ball_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] winner
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic [3:0] C_WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [7:0] C_LAST_FRAME = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] C_SCORE_MAX  = 4'd15;

  localparam logic [1:0] C_WIN_NONE  = 2'b00;
  localparam logic [1:0] C_WIN_LEFT  = 2'b01;
  localparam logic [1:0] C_WIN_RIGHT = 2'b10;

  logic       r_sync1;
  logic       r_sync2;
  logic       r_sync2_d;
  logic [2:0] r_vld;
  logic       r_start_p;
  logic [7:0] r_frame_cnt;

  logic [2:0] w_state_nxt;
  logic [3:0] w_score_l_nxt;
  logic [3:0] w_score_r_nxt;
  logic [1:0] w_winner_nxt;
  logic       w_serve_dir_nxt;
  logic [7:0] w_frame_cnt_nxt;

  // Button synchroniser and rising-edge detector. r_vld marks when r_sync2_d
  // holds a genuine post-reset sample, so a button already held high across
  // reset release is not mistaken for a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_d <= 1'b0;
      r_vld     <= 3'b000;
      r_start_p <= 1'b0;
    end else begin
      r_sync1   <= start_btn;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
      r_vld     <= {r_vld[1:0], 1'b1};
      r_start_p <= r_sync2 & ~r_sync2_d & r_vld[2];
    end
  end

  // Next-state and next-score decisions for the match sequencer.
  always_comb begin
    w_state_nxt     = state;
    w_score_l_nxt   = score_l;
    w_score_r_nxt   = score_r;
    w_winner_nxt    = winner;
    w_serve_dir_nxt = serve_dir;
    w_frame_cnt_nxt = r_frame_cnt;
    case (state)
      ST_IDLE: begin
        if (r_start_p) begin
          w_score_l_nxt   = 4'd0;
          w_score_r_nxt   = 4'd0;
          w_winner_nxt    = C_WIN_NONE;
          w_serve_dir_nxt = 1'b1;
          w_frame_cnt_nxt = 8'd0;
          w_state_nxt     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (r_frame_cnt == C_LAST_FRAME) begin
            w_frame_cnt_nxt = 8'd0;
            w_state_nxt     = ST_PLAY;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + 8'd1;
          end
        end
      end
      ST_PLAY: begin
        if (miss_left && miss_right) begin
          // Simultaneous misses: nobody scores, serve again.
          w_frame_cnt_nxt = 8'd0;
          w_state_nxt     = ST_SERVE;
        end else if (miss_left) begin
          w_score_r_nxt   = (score_r == C_SCORE_MAX) ? score_r : score_r + 4'd1;
          w_serve_dir_nxt = 1'b0;
          w_state_nxt     = ST_POINT;
        end else if (miss_right) begin
          w_score_l_nxt   = (score_l == C_SCORE_MAX) ? score_l : score_l + 4'd1;
          w_serve_dir_nxt = 1'b1;
          w_state_nxt     = ST_POINT;
        end
      end
      ST_POINT: begin
        if (score_l == C_WIN_VAL) begin
          w_winner_nxt = C_WIN_LEFT;
          w_state_nxt  = ST_OVER;
        end else if (score_r == C_WIN_VAL) begin
          w_winner_nxt = C_WIN_RIGHT;
          w_state_nxt  = ST_OVER;
        end else begin
          w_frame_cnt_nxt = 8'd0;
          w_state_nxt     = ST_SERVE;
        end
      end
      ST_OVER: begin
        if (r_start_p) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered state, scores and Moore outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ball_en     <= 1'b0;
      ball_reset  <= 1'b1;
      serve_dir   <= 1'b1;
      score_l     <= 4'd0;
      score_r     <= 4'd0;
      winner      <= C_WIN_NONE;
      r_frame_cnt <= 8'd0;
    end else begin
      state       <= w_state_nxt;
      ball_en     <= (w_state_nxt == ST_PLAY);
      ball_reset  <= (w_state_nxt != ST_PLAY);
      serve_dir   <= w_serve_dir_nxt;
      score_l     <= w_score_l_nxt;
      score_r     <= w_score_r_nxt;
      winner      <= w_winner_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

endmodule
`default_nettype wire
